apb3_arbiter: RTL and testbench

Two-master APB3 arbiter sharing one downstream APB3 slave bus, e.g. the SoC APB3 port and a debug/host requester driving one `apb3_slave` register bank. Grants whole transfers round-robin, re-times each granted transfer onto the downstream bus, and returns the response to the owning master only. A watchdog aborts downstream transfers that never complete.

---
 rtl/apb3_arbiter_pkg.sv | 15 +
 rtl/apb3_rr_pick.sv | 33 +++
 rtl/apb3_arbiter.sv | 154 +++++++++++++++
 tb/tb_apb3_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb3_arbiter_pkg.sv
// Shared types and defaults for the two-master APB3 arbiter.
package apb3_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int WDOG_WIDTH     = 16;

endpackage

// File: rtl/apb3_rr_pick.sv
// Two-way round-robin picker: a tie goes to the master that did not win last time.
module apb3_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       grant_o
);

    // grant_o is only meaningful while valid_o is high
    always_comb begin
        valid_o = 1'b0;
        grant_o = 1'b0;
        case (req_i)
            2'b01: begin
                valid_o = 1'b1;
                grant_o = 1'b0;
            end
            2'b10: begin
                valid_o = 1'b1;
                grant_o = 1'b1;
            end
            2'b11: begin
                valid_o = 1'b1;
                grant_o = ~last_i;
            end
            default: begin
                valid_o = 1'b0;
                grant_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/apb3_arbiter.sv
// Two-master APB3 arbiter: grants whole transfers round-robin, re-times them onto one
// downstream APB3 bus and aborts downstream transfers that exceed the watchdog limit.
module apb3_arbiter
    import apb3_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] M0_PADDR,
    input  logic                  M0_PSEL,
    input  logic                  M0_PENABLE,
    input  logic                  M0_PWRITE,
    input  logic [DATA_WIDTH-1:0] M0_PWDATA,
    output logic                  M0_PREADY,
    output logic [DATA_WIDTH-1:0] M0_PRDATA,
    output logic                  M0_PSLVERROR,
    input  logic [ADDR_WIDTH-1:0] M1_PADDR,
    input  logic                  M1_PSEL,
    input  logic                  M1_PENABLE,
    input  logic                  M1_PWRITE,
    input  logic [DATA_WIDTH-1:0] M1_PWDATA,
    output logic                  M1_PREADY,
    output logic [DATA_WIDTH-1:0] M1_PRDATA,
    output logic                  M1_PSLVERROR,
    output logic [ADDR_WIDTH-1:0] S_PADDR,
    output logic                  S_PSEL,
    output logic                  S_PENABLE,
    output logic                  S_PWRITE,
    output logic [DATA_WIDTH-1:0] S_PWDATA,
    input  logic                  S_PREADY,
    input  logic [DATA_WIDTH-1:0] S_PRDATA,
    input  logic                  S_PSLVERROR,
    output logic                  grant,
    output logic                  busy
);

    // Watchdog counts completed wait cycles; abort happens on the TIMEOUT-th ACCESS cycle.
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(TIMEOUT - 1);

    arb_state_e            state_q;
    logic                  last_q;
    logic                  grant_q;
    logic                  busy_q;
    logic [WDOG_WIDTH-1:0] wdog_q;
    logic [ADDR_WIDTH-1:0] s_paddr_q;
    logic                  s_psel_q;
    logic                  s_penable_q;
    logic                  s_pwrite_q;
    logic [DATA_WIDTH-1:0] s_pwdata_q;
    logic [1:0]            pready_q;
    logic [DATA_WIDTH-1:0] m0_prdata_q;
    logic [DATA_WIDTH-1:0] m1_prdata_q;
    logic                  m0_pslverr_q;
    logic                  m1_pslverr_q;
    logic                  pick_valid_s;
    logic                  pick_grant_s;

    // PENABLE is not needed for arbitration: a master requests from its setup phase on.
    apb3_rr_pick u_pick (
        .req_i   ({M1_PSEL, M0_PSEL}),
        .last_i  (last_q),
        .valid_o (pick_valid_s),
        .grant_o (pick_grant_s)
    );

    // Transfer FSM, watchdog and all registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            wdog_q       <= '0;
            s_paddr_q    <= '0;
            s_psel_q     <= 1'b0;
            s_penable_q  <= 1'b0;
            s_pwrite_q   <= 1'b0;
            s_pwdata_q   <= '0;
            pready_q     <= 2'b00;
            m0_prdata_q  <= '0;
            m1_prdata_q  <= '0;
            m0_pslverr_q <= 1'b0;
            m1_pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        state_q    <= ST_SETUP;
                        busy_q     <= 1'b1;
                        grant_q    <= pick_grant_s;
                        last_q     <= pick_grant_s;
                        wdog_q     <= '0;
                        s_psel_q   <= 1'b1;
                        s_paddr_q  <= pick_grant_s ? M1_PADDR  : M0_PADDR;
                        s_pwrite_q <= pick_grant_s ? M1_PWRITE : M0_PWRITE;
                        s_pwdata_q <= pick_grant_s ? M1_PWDATA : M0_PWDATA;
                    end
                end
                ST_SETUP: begin
                    s_penable_q <= 1'b1;
                    state_q     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (S_PREADY || (wdog_q == WDOG_LAST)) begin
                        // a late S_PREADY on the final watchdog cycle still counts as success
                        state_q     <= ST_DONE;
                        s_psel_q    <= 1'b0;
                        s_penable_q <= 1'b0;
                        pready_q    <= grant_q ? 2'b10 : 2'b01;
                        if (grant_q) begin
                            m1_prdata_q  <= S_PREADY ? S_PRDATA : '0;
                            m1_pslverr_q <= S_PREADY ? S_PSLVERROR : 1'b1;
                        end else begin
                            m0_prdata_q  <= S_PREADY ? S_PRDATA : '0;
                            m0_pslverr_q <= S_PREADY ? S_PSLVERROR : 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + {{(WDOG_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    pready_q <= 2'b00;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    s_psel_q    <= 1'b0;
                    s_penable_q <= 1'b0;
                    pready_q    <= 2'b00;
                end
            endcase
        end
    end

    assign S_PADDR      = s_paddr_q;
    assign S_PSEL       = s_psel_q;
    assign S_PENABLE    = s_penable_q;
    assign S_PWRITE     = s_pwrite_q;
    assign S_PWDATA     = s_pwdata_q;
    assign M0_PREADY    = pready_q[0];
    assign M1_PREADY    = pready_q[1];
    assign M0_PRDATA    = m0_prdata_q;
    assign M1_PRDATA    = m1_prdata_q;
    assign M0_PSLVERROR = m0_pslverr_q;
    assign M1_PSLVERROR = m1_pslverr_q;
    assign grant        = grant_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_apb3_arbiter.sv
// Bench for apb3_arbiter: two bench masters, a behavioural register-bank slave and a
// transaction-level reference (round-robin order applied to a reference memory).
module tb_apb3_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int NW  = 16;
    localparam int NRR = 6;
    localparam logic [DW-1:0] ERR_DATA = 32'hBAD0_0000;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] m_paddr   [2];
    logic          m_psel    [2];
    logic          m_penable [2];
    logic          m_pwrite  [2];
    logic [DW-1:0] m_pwdata  [2];
    logic          m_pready  [2];
    logic [DW-1:0] m_prdata  [2];
    logic          m_pslverr [2];
    logic [AW-1:0] s_paddr;
    logic          s_psel, s_penable, s_pwrite;
    logic [DW-1:0] s_pwdata;
    logic          s_pready;
    logic [DW-1:0] s_prdata;
    logic          s_pslverr;
    logic          grant, busy;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            model_last = 1;
    logic [DW-1:0] slv_mem [NW];
    logic [DW-1:0] ref_mem [NW];
    bit            never_ready = 1'b0;
    bit            wait_rand = 1'b0;
    int            wait_fixed = 0;
    int            grant_log [$];
    int            penable_cnt = 0;
    bit            m1_ready_seen = 1'b0;
    bit            busy_hist [int];

    apb3_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .M0_PADDR(m_paddr[0]), .M0_PSEL(m_psel[0]), .M0_PENABLE(m_penable[0]),
        .M0_PWRITE(m_pwrite[0]), .M0_PWDATA(m_pwdata[0]), .M0_PREADY(m_pready[0]),
        .M0_PRDATA(m_prdata[0]), .M0_PSLVERROR(m_pslverr[0]),
        .M1_PADDR(m_paddr[1]), .M1_PSEL(m_psel[1]), .M1_PENABLE(m_penable[1]),
        .M1_PWRITE(m_pwrite[1]), .M1_PWDATA(m_pwdata[1]), .M1_PREADY(m_pready[1]),
        .M1_PRDATA(m_prdata[1]), .M1_PSLVERROR(m_pslverr[1]),
        .S_PADDR(s_paddr), .S_PSEL(s_psel), .S_PENABLE(s_penable), .S_PWRITE(s_pwrite),
        .S_PWDATA(s_pwdata), .S_PREADY(s_pready), .S_PRDATA(s_prdata),
        .S_PSLVERROR(s_pslverr), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: grant of each downstream SETUP, ACCESS-cycle count, busy history, stray M1 ready
    initial begin
        forever begin
            @(negedge clk);
            busy_hist[cyc] = busy;
            if (resetn) begin
                if (s_psel && !s_penable) grant_log.push_back(int'(grant));
                if (s_penable) penable_cnt++;
                if (m_pready[1]) m1_ready_seen = 1'b1;
            end
        end
    end

    // Behavioural slave: configurable wait states, error above 0x0FF, optional never-ready
    initial begin
        int slv_cnt;
        int slv_wait;
        slv_cnt = 0;
        slv_wait = 0;
        s_pready = 1'b0;
        s_prdata = '0;
        s_pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                s_pready = 1'b0;
                s_pslverr = 1'b0;
                slv_cnt = 0;
            end else if (s_psel && s_penable) begin
                if (never_ready || slv_cnt < slv_wait) begin
                    s_pready = 1'b0;
                    slv_cnt++;
                end else begin
                    s_pready = 1'b1;
                    s_pslverr = (s_paddr >= 12'h100);
                    if (s_pwrite) begin
                        s_prdata = '0;
                        if (!s_pslverr) slv_mem[s_paddr[5:2]] = s_pwdata;
                    end else begin
                        s_prdata = s_pslverr ? ERR_DATA : slv_mem[s_paddr[5:2]];
                    end
                end
            end else begin
                s_pready = 1'b0;
                s_pslverr = 1'b0;
                slv_cnt = 0;
                slv_wait = wait_rand ? int'($urandom_range(0, 2)) : wait_fixed;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at time %0t", $time);
        $fatal(1, "global timeout");
    end

    function automatic logic [127:0] all_outputs();
        return {11'd0, s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
                m_pready[0], m_pready[1], m_pslverr[0], m_pslverr[1],
                m_prdata[0], m_prdata[1], grant, busy};
    endfunction

    // Called at a falling edge; returns at the falling edge after completion with PSEL still high.
    task automatic apb_xfer(input int m, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                            output bit err, output int lat);
        int start;
        start = cyc;
        m_paddr[m] = addr;
        m_pwrite[m] = wr;
        m_pwdata[m] = wdata;
        m_psel[m] = 1'b1;
        m_penable[m] = 1'b0;
        @(negedge clk);
        m_penable[m] = 1'b1;
        while (m_pready[m] !== 1'b1 && (cyc - start) < 100) @(negedge clk);
        lat = cyc - start;
        rdata = m_prdata[m];
        err = m_pslverr[m];
        if (m_pready[m] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL xfer_bound m%0d: no PREADY after %0d cycles, required within 100", m, lat);
            lat = -1;
        end
        @(negedge clk);
    endtask

    task automatic master_idle(input int m);
        m_psel[m] = 1'b0;
        m_penable[m] = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] v;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        v = all_outputs();
        checks++;
        if (v !== 128'd0) begin errors++; $display("FAIL reset_outputs: got %h required 0", v); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        v = all_outputs();
        checks++;
        if (v !== 128'd0) begin errors++; $display("FAIL idle_outputs: got %h required 0", v); end
        model_last = 1;
    endtask

    task automatic test_contention();
        logic [DW-1:0] rd0, rd1, old;
        bit e0, e1;
        int l0, l1, t0, lows;
        old = ref_mem[1];
        grant_log.delete();
        t0 = cyc;
        fork
            apb_xfer(0, 1'b0, 12'h004, 32'h0, rd0, e0, l0);
            apb_xfer(1, 1'b1, 12'h004, 32'hA5, rd1, e1, l1);
        join
        master_idle(0);
        master_idle(1);
        ref_mem[1] = 32'hA5;
        model_last = 1;
        checks++;
        if (!(grant_log.size() == 2 && grant_log[0] == 0 && grant_log[1] == 1)) begin
            errors++;
            $display("FAIL contention_order: got %p required '{0,1}", grant_log);
        end
        checks++;
        if (rd0 !== old || e0 !== 1'b0) begin
            errors++; $display("FAIL contention_m0_read: got %h err %0b required %h err 0", rd0, e0, old);
        end
        checks++;
        if (l0 != 3 || l1 != 7) begin
            errors++; $display("FAIL contention_latency: got m0 %0d m1 %0d required 3 7", l0, l1);
        end
        lows = 0;
        for (int c = t0 + 1; c <= t0 + 7; c++) if (busy_hist.exists(c) && !busy_hist[c]) lows++;
        checks++;
        if (lows != 1 || !busy_hist.exists(t0 + 4) || busy_hist[t0 + 4] !== 1'b0) begin
            errors++; $display("FAIL contention_busy_gap: got %0d low cycles required exactly 1 at cycle 4", lows);
        end
        checks++;
        if (slv_mem[1] !== 32'hA5) begin
            errors++; $display("FAIL contention_m1_write: got %h required %h", slv_mem[1], 32'hA5);
        end
    endtask

    task automatic test_single_write();
        logic [DW-1:0] rd;
        bit e;
        int lat;
        m1_ready_seen = 1'b0;
        fork
            apb_xfer(0, 1'b1, 12'h000, 32'h5, rd, e, lat);
            begin
                @(negedge clk);
                checks++;
                if (s_psel !== 1'b1 || s_penable !== 1'b0) begin
                    errors++; $display("FAIL single_setup: got psel %0b penable %0b required 1 0", s_psel, s_penable);
                end
                @(negedge clk);
                checks++;
                if (s_psel !== 1'b1 || s_penable !== 1'b1 || s_paddr !== 12'h000 || s_pwrite !== 1'b1 || s_pwdata !== 32'h5) begin
                    errors++;
                    $display("FAIL single_access: got psel %0b penable %0b addr %h wr %0b wdata %h required 1 1 000 1 5",
                             s_psel, s_penable, s_paddr, s_pwrite, s_pwdata);
                end
            end
        join
        master_idle(0);
        ref_mem[0] = 32'h5;
        model_last = 0;
        checks++;
        if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d required 3", lat); end
        checks++;
        if (m_pready[0] !== 1'b0) begin errors++; $display("FAIL single_pready_pulse: got %0b required 0", m_pready[0]); end
        checks++;
        if (slv_mem[0] !== 32'h5) begin errors++; $display("FAIL single_reg0: got %h required 5", slv_mem[0]); end
        repeat (2) @(negedge clk);
        checks++;
        if (m1_ready_seen !== 1'b0) begin errors++; $display("FAIL single_m1_ready: got 1 required 0"); end
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] rd;
        bit e;
        int lat;
        wait_fixed = 3;
        @(negedge clk);
        apb_xfer(0, 1'b0, 12'h008, 32'h0, rd, e, lat);
        master_idle(0);
        wait_fixed = 0;
        model_last = 0;
        checks++;
        if (lat != 6 || rd !== ref_mem[2] || e !== 1'b0) begin
            errors++; $display("FAIL wait3: got lat %0d data %h err %0b required 6 %h 0", lat, rd, e, ref_mem[2]);
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd;
        bit e;
        int lat, pe0;
        never_ready = 1'b1;
        @(negedge clk);
        pe0 = penable_cnt;
        apb_xfer(0, 1'b0, 12'h00C, 32'h0, rd, e, lat);
        master_idle(0);
        never_ready = 1'b0;
        checks++;
        if (lat != TMO + 2 || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL timeout_abort: got lat %0d err %0b data %h required %0d 1 0", lat, e, rd, TMO + 2);
        end
        checks++;
        if (penable_cnt - pe0 != TMO) begin
            errors++; $display("FAIL timeout_access_cycles: got %0d required %0d", penable_cnt - pe0, TMO);
        end
        wait_fixed = TMO - 1;
        @(negedge clk);
        apb_xfer(1, 1'b0, 12'h010, 32'h0, rd, e, lat);
        master_idle(1);
        wait_fixed = 0;
        checks++;
        if (lat != TMO + 2 || e !== 1'b0 || rd !== ref_mem[4]) begin
            errors++; $display("FAIL timeout_ready_wins: got lat %0d err %0b data %h required %0d 0 %h", lat, e, rd, TMO + 2, ref_mem[4]);
        end
        @(negedge clk);
        apb_xfer(0, 1'b0, 12'h014, 32'h0, rd, e, lat);
        master_idle(0);
        model_last = 0;
        checks++;
        if (lat != 3 || e !== 1'b0 || rd !== ref_mem[5]) begin
            errors++; $display("FAIL timeout_recovery: got lat %0d err %0b data %h required 3 0 %h", lat, e, rd, ref_mem[5]);
        end
    endtask

    task automatic test_round_robin();
        bit            tx_wr   [2][NRR];
        logic [AW-1:0] tx_addr [2][NRR];
        logic [DW-1:0] tx_wd   [2][NRR];
        logic [DW-1:0] res_rd  [2][NRR];
        bit            res_err [2][NRR];
        int            res_lat [2][NRR];
        int            first, m, i, bad_order;
        logic [DW-1:0] exp_rd;
        bit            exp_err;
        for (int mm = 0; mm < 2; mm++) begin
            for (int k = 0; k < NRR; k++) begin
                tx_wr[mm][k] = ($urandom_range(0, 2) == 0);
                tx_addr[mm][k] = AW'($urandom_range(0, NW - 1) * 4);
                if ($urandom_range(0, 5) == 0) tx_addr[mm][k] = tx_addr[mm][k] + 12'h100;
                tx_wd[mm][k] = $urandom;
            end
        end
        grant_log.delete();
        wait_rand = 1'b1;
        @(negedge clk);
        fork
            begin
                for (int k = 0; k < NRR; k++)
                    apb_xfer(0, tx_wr[0][k], tx_addr[0][k], tx_wd[0][k], res_rd[0][k], res_err[0][k], res_lat[0][k]);
                master_idle(0);
            end
            begin
                for (int k = 0; k < NRR; k++)
                    apb_xfer(1, tx_wr[1][k], tx_addr[1][k], tx_wd[1][k], res_rd[1][k], res_err[1][k], res_lat[1][k]);
                master_idle(1);
            end
        join
        wait_rand = 1'b0;
        first = 1 - model_last;
        bad_order = 0;
        for (int k = 0; k < 2 * NRR; k++) begin
            m = (k % 2 == 0) ? first : 1 - first;
            i = k / 2;
            exp_err = (tx_addr[m][i] >= 12'h100);
            if (tx_wr[m][i]) begin
                exp_rd = '0;
                if (!exp_err) ref_mem[tx_addr[m][i][5:2]] = tx_wd[m][i];
            end else begin
                exp_rd = exp_err ? ERR_DATA : ref_mem[tx_addr[m][i][5:2]];
            end
            checks++;
            if (res_rd[m][i] !== exp_rd || res_err[m][i] !== exp_err) begin
                errors++;
                $display("FAIL rr_data m%0d #%0d: got %h err %0b required %h err %0b", m, i, res_rd[m][i], res_err[m][i], exp_rd, exp_err);
            end
            if (k >= grant_log.size() || grant_log[k] != m) bad_order++;
        end
        model_last = 1 - first;
        checks++;
        if (bad_order != 0 || grant_log.size() != 2 * NRR) begin
            errors++; $display("FAIL rr_alternation: got %p required alternating starting with %0d", grant_log, first);
        end
        for (int w = 0; w < NW; w++) begin
            checks++;
            if (slv_mem[w] !== ref_mem[w]) begin
                errors++; $display("FAIL rr_mem[%0d]: got %h required %h", w, slv_mem[w], ref_mem[w]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] rd0, rd1;
        bit e0, e1;
        int l0, l1;
        logic [127:0] v;
        never_ready = 1'b1;
        @(negedge clk);
        m_paddr[1] = 12'h018;
        m_pwrite[1] = 1'b0;
        m_psel[1] = 1'b1;
        m_penable[1] = 1'b0;
        @(negedge clk);
        m_penable[1] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (s_penable !== 1'b1) begin errors++; $display("FAIL midreset_in_access: got penable %0b required 1", s_penable); end
        resetn = 1'b0;
        #1;
        v = all_outputs();
        checks++;
        if (v !== 128'd0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", v); end
        master_idle(1);
        never_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        grant_log.delete();
        fork
            apb_xfer(0, 1'b0, 12'h01C, 32'h0, rd0, e0, l0);
            apb_xfer(1, 1'b0, 12'h020, 32'h0, rd1, e1, l1);
        join
        master_idle(0);
        master_idle(1);
        model_last = 1;
        checks++;
        if (!(grant_log.size() == 2 && grant_log[0] == 0 && grant_log[1] == 1) || l0 != 3 || l1 != 7) begin
            errors++; $display("FAIL midreset_m0_first: got %p lat %0d %0d required '{0,1} 3 7", grant_log, l0, l1);
        end
        checks++;
        if (rd0 !== ref_mem[7] || rd1 !== ref_mem[8] || e0 !== 1'b0 || e1 !== 1'b0) begin
            errors++; $display("FAIL midreset_data: got %h %h required %h %h", rd0, rd1, ref_mem[7], ref_mem[8]);
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_paddr[m] = '0;
            m_psel[m] = 1'b0;
            m_penable[m] = 1'b0;
            m_pwrite[m] = 1'b0;
            m_pwdata[m] = '0;
        end
        for (int w = 0; w < NW; w++) begin
            slv_mem[w] = $urandom | 32'h1;
            ref_mem[w] = slv_mem[w];
        end
        @(negedge clk);
        test_reset();
        test_contention();
        test_single_write();
        test_wait_states();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
